fifo_stream_out: RTL and testbench

FIFO_STREAM_OUT -- requirements
Module: fifo_stream_out

---
 rtl/fifo_stream_pkg.sv | 13 +
 rtl/fifo_stream_skid_buf.sv | 55 +++++
 rtl/fifo_stream_out.sv | 60 ++++++
 tb/tb_fifo_stream_out.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared sizing for the async-FIFO read-side stream adapter.
// Pointer helper wraps mod BUF_DEPTH.
package fifo_stream_pkg;
  localparam int BUF_DEPTH = 3;
  localparam int LEVEL_W   = 2;
  localparam int CNT_W     = 16;

  function automatic logic [LEVEL_W-1:0] ptr_inc(
    input logic [LEVEL_W-1:0] p
  );
    return (p == LEVEL_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
endpackage

// File: rtl/fifo_stream_skid_buf.sv
// Three-entry circular buffer between the FIFO read port and the stream.
// Push writes at tail, pop advances head; level tracks occupancy.
module fifo_stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [DW-1:0]      push_data,
  input  logic               pop,
  output logic [DW-1:0]      head_data,
  output logic [LEVEL_W-1:0] level
);
  logic [DW-1:0]      mem_q [BUF_DEPTH];
  logic [DW-1:0]      mem_d [BUF_DEPTH];
  logic [LEVEL_W-1:0] head_q, head_d;
  logic [LEVEL_W-1:0] tail_q, tail_d;
  logic [LEVEL_W-1:0] level_q, level_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    if (push) begin
      mem_d[tail_q] = push_data;
      tail_d        = ptr_inc(tail_q);
    end
    if (pop) head_d = ptr_inc(head_q);
    unique case (1'b1)
      push && !pop: level_d = level_q + 1'b1;
      pop && !push: level_d = level_q - 1'b1;
      default:      level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

  assign head_data = mem_q[head_q];
  assign level     = level_q;
endmodule

// File: rtl/fifo_stream_out.sv
// Turns a registered async-FIFO read port into a valid/ready stream.
// Define FIFO_STREAM_OUT_CNT_EN to enable the xfer_cnt counter.
module fifo_stream_out
  import fifo_stream_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic               rclk,
  input  logic               wrst_n,
  input  logic               fifo_rempty,
  output logic               fifo_ren,
  input  logic [DW-1:0]      fifo_rdata,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DW-1:0]      m_data,
  output logic [LEVEL_W-1:0] m_level,
  output logic [CNT_W-1:0]   xfer_cnt
);
  logic             inflight_q, inflight_d;
  logic             xfer;
  logic [LEVEL_W:0] occ;

  // Reserve a slot for the word already in flight so the buffer never overflows.
  assign occ = {1'b0, m_level} + {{LEVEL_W{1'b0}}, inflight_q};
  assign fifo_ren = wrst_n & ~fifo_rempty
                  & (occ < (LEVEL_W+1)'(BUF_DEPTH));
  assign inflight_d = fifo_ren & ~fifo_rempty;
  assign m_valid = (m_level != '0);
  assign xfer = m_valid & m_ready;

  always_ff @(posedge rclk or negedge wrst_n) begin
    if (!wrst_n) inflight_q <= 1'b0;
    else         inflight_q <= inflight_d;
  end

  fifo_stream_skid_buf #(.DW(DW)) u_buf (
    .clk       (rclk),
    .rst_n     (wrst_n),
    .push      (inflight_q),
    .push_data (fifo_rdata),
    .pop       (xfer),
    .head_data (m_data),
    .level     (m_level)
  );

`ifdef FIFO_STREAM_OUT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = cnt_q + CNT_W'(xfer);
  always_ff @(posedge rclk or negedge wrst_n) begin
    if (!wrst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = '0;
`endif

  no_overflow: assert property (@(posedge rclk) disable iff (!wrst_n)
    !(m_level == LEVEL_W'(BUF_DEPTH) && inflight_q));
endmodule

// File: tb/tb_fifo_stream_out.sv
// Directed bench for fifo_stream_out with a behavioural upstream FIFO.
// Expected values are hand-derived from the read-latency timing.
module tb_fifo_stream_out;
  logic        rclk = 1'b0;
  logic        wrst_n;
  logic        fifo_rempty;
  logic        fifo_ren;
  logic [7:0]  fifo_rdata;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [1:0]  m_level;
  logic [15:0] xfer_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit tog = 1'b0;

  logic [7:0] up_mem [0:63];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int pop_cnt = 0;
  int base;

`ifdef FIFO_STREAM_OUT_CNT_EN
  localparam logic [15:0] CNT_AFTER_C4 = 16'd1;
  localparam logic [15:0] CNT_AFTER_D  = 16'h0001;
`else
  localparam logic [15:0] CNT_AFTER_C4 = 16'd0;
  localparam logic [15:0] CNT_AFTER_D  = 16'd0;
`endif

  always #5 rclk = ~rclk;

  fifo_stream_out #(.DW(8)) u_dut (
    .rclk        (rclk),
    .wrst_n      (wrst_n),
    .fifo_rempty (fifo_rempty),
    .fifo_ren    (fifo_ren),
    .fifo_rdata  (fifo_rdata),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_level     (m_level),
    .xfer_cnt    (xfer_cnt)
  );

  assign fifo_rempty = (rd_ptr == wr_ptr);

  always @(posedge rclk or negedge wrst_n) begin
    if (!wrst_n) begin
      fifo_rdata <= '0;
    end else if (fifo_ren && !fifo_rempty) begin
      fifo_rdata <= up_mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
      pop_cnt    <= pop_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge rclk);
    if (tog) m_ready = ~m_ready;
  endtask

  task automatic load(input logic [7:0] w);
    up_mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic expect_word(input string tag, input logic [7:0] w);
    int n = 0;
    while (!(m_valid && m_ready) && n < 12) begin
      step();
      n++;
    end
    chk({tag, "_seen"}, 16'(m_valid && m_ready), 16'd1);
    chk(tag, 16'(m_data), 16'(w));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    wrst_n  = 1'b0;
    m_ready = 1'b1;
    load(8'h11); load(8'h22); load(8'h33); load(8'h44);
    #2;
    chk("rst_ren",   16'(fifo_ren), 16'd0);
    chk("rst_valid", 16'(m_valid),  16'd0);
    chk("rst_level", 16'(m_level),  16'd0);
    chk("rst_cnt",   xfer_cnt,      16'd0);
    chk("rst_data",  16'(m_data),   16'd0);
    step(); step();
    chk("rst_ren2",  16'(fifo_ren), 16'd0);
    chk("rst_pops",  16'(pop_cnt),  16'd0);
    wrst_n = 1'b1;

    step();
    chk("s1_ren",   16'(fifo_ren), 16'd1);
    chk("s1_valid", 16'(m_valid),  16'd0);
    chk("s1_pops",  16'(pop_cnt),  16'd1);
    step();
    chk("s2_valid", 16'(m_valid), 16'd1);
    chk("s2_d11",   16'(m_data),  16'h11);
    step();
    chk("s3_d22",   16'(m_data),  16'h22);
    step();
    chk("s4_d33",   16'(m_data),  16'h33);
    step();
    chk("s5_valid", 16'(m_valid), 16'd1);
    chk("s5_d44",   16'(m_data),  16'h44);
    step();
    chk("s6_valid", 16'(m_valid), 16'd0);
    chk("s6_ren",   16'(fifo_ren), 16'd0);

    m_ready = 1'b0;
    base = pop_cnt;
    load(8'hA1); load(8'hA2); load(8'hA3); load(8'hA4); load(8'hA5);
    step(); step(); step(); step();
    chk("bp_level", 16'(m_level), 16'd3);
    chk("bp_ren",   16'(fifo_ren), 16'd0);
    chk("bp_head",  16'(m_data),  16'hA1);
    chk("bp_pops",  16'(pop_cnt - base), 16'd3);
    step();
    chk("bp_hold",  16'(m_data),  16'hA1);
    chk("bp_pops2", 16'(pop_cnt - base), 16'd3);
    m_ready = 1'b1;
    expect_word("bp_a1", 8'hA1);
    expect_word("bp_a2", 8'hA2);
    expect_word("bp_a3", 8'hA3);
    expect_word("bp_a4", 8'hA4);
    expect_word("bp_a5", 8'hA5);
    chk("bp_empty", 16'(m_valid), 16'd0);

    for (int i = 0; i < 8; i++) load(8'hB0 + 8'(i));
    tog = 1'b1;
    for (int i = 0; i < 8; i++) expect_word("tog_b", 8'hB0 + 8'(i));
    tog = 1'b0;
    m_ready = 1'b1;
    step();
    chk("tog_level", 16'(m_level), 16'd0);
    chk("tog_pops",  16'(rd_ptr),  16'(wr_ptr));

    m_ready = 1'b0;
    load(8'hC1); load(8'hC2); load(8'hC3); load(8'hC4);
    step(); step(); step();
    chk("mid_level", 16'(m_level), 16'd2);
    chk("mid_infl",  16'(u_dut.inflight_q), 16'd1);
    #1 wrst_n = 1'b0;
    #1;
    chk("mr_level", 16'(m_level),  16'd0);
    chk("mr_valid", 16'(m_valid),  16'd0);
    chk("mr_ren",   16'(fifo_ren), 16'd0);
    chk("mr_data",  16'(m_data),   16'd0);
    chk("mr_cnt",   xfer_cnt,      16'd0);
    chk("mr_infl",  16'(u_dut.inflight_q), 16'd0);
    step();
    wrst_n  = 1'b1;
    m_ready = 1'b1;
    expect_word("mr_c4", 8'hC4);
    chk("mr_cnt2", xfer_cnt, CNT_AFTER_C4);

`ifdef FIFO_STREAM_OUT_CNT_EN
    force u_dut.cnt_q = 16'hFFFE;
    #1 release u_dut.cnt_q;
`endif
    load(8'hD1); load(8'hD2); load(8'hD3);
    expect_word("cnt_d1", 8'hD1);
    expect_word("cnt_d2", 8'hD2);
    expect_word("cnt_d3", 8'hD3);
    chk("cnt_wrap", xfer_cnt, CNT_AFTER_D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
